// File: rtl/alu_exec_if.sv
// Request/response handshake bundle for alu_exec_stage.
//   master : upstream producer / downstream consumer side (drives requests and out_ready)
//   slave  : the execute stage (drives in_ready and the result fields)
//   in_valid/in_ready   request handshake
//   in_a/in_b/in_op     request payload (signed operands, 3-bit op)
//   out_valid/out_ready result handshake
//   out_z/out_zero      captured ALU result and zero/ex flag
//   out_illegal         op outside the supported set (only when the check is built in)
interface alu_exec_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_z;
  logic             out_zero;
  logic             out_illegal;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_z, out_zero, out_illegal
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_z, out_zero, out_illegal
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Single-slot execute stage wrapped around an external combinational ALU.
// A request is registered onto the ALU operand ports, the ALU is given one
// full cycle, and the result is captured and held until the consumer takes it.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   bus (slave)       request/response handshake, see alu_exec_if
//   alu_a/alu_b/alu_op registered operands/op to the ALU, stable between accepts
//   alu_z/alu_ex      ALU combinational result and zero/ex flag
//   op_count          completed handoffs, saturating at 2^CNT_W-1
// Build option:
//   ALU_EXEC_ILLEGAL_CHK_EN  when defined, ops 3/4/5 raise out_illegal and
//                            force a zero result/flag; otherwise out_illegal is 0
//                            and the ALU output is captured for every op.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exec_if.slave        bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_ex,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_z_q;
  logic             out_zero_q;

`ifdef ALU_EXEC_ILLEGAL_CHK_EN
  logic illegal_q;
  logic illegal_c;

  // Ops 3, 4 and 5 have no defined ALU function.
  assign illegal_c = (alu_op == 3'd3) || (alu_op == 3'd4) || (alu_op == 3'd5);
  assign bus.out_illegal = illegal_q;
`else
  assign bus.out_illegal = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_z     = out_z_q;
  assign bus.out_zero  = out_zero_q;

  // Stage FSM; in_ready/out_valid are registered alongside the state so they
  // mirror IDLE/HOLD exactly without a decode after the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      alu_a       <= WIDTH'(0);
      alu_b       <= WIDTH'(0);
      alu_op      <= 3'd0;
      out_z_q     <= WIDTH'(0);
      out_zero_q  <= 1'b0;
      op_count    <= CNT_W'(0);
`ifdef ALU_EXEC_ILLEGAL_CHK_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            alu_a      <= bus.in_a;
            alu_b      <= bus.in_b;
            alu_op     <= bus.in_op;
            in_ready_q <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
`ifdef ALU_EXEC_ILLEGAL_CHK_EN
          out_z_q    <= illegal_c ? WIDTH'(0) : alu_z;
          out_zero_q <= illegal_c ? 1'b0 : alu_ex;
          illegal_q  <= illegal_c;
`else
          out_z_q    <= alu_z;
          out_zero_q <= alu_ex;
`endif
          out_valid_q <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          // Handoff cycle: return to IDLE, so the next accept is one edge later.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
            if (op_count != {CNT_W{1'b1}}) begin
              op_count <= op_count + CNT_W'(1);
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed testbench for alu_exec_stage with a behavioural ALU model.
module tb_alu_exec_stage;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  alu_exec_if #(.WIDTH(32)) bus ();
  alu_exec_if #(.WIDTH(32)) bus2 ();

  logic [31:0] alu_a, alu_b, alu_z;
  logic [2:0]  alu_op;
  logic        alu_ex;
  logic [15:0] op_count;

  logic [31:0] alu_a2, alu_b2, alu_z2;
  logic [2:0]  alu_op2;
  logic        alu_ex2;
  logic [1:0]  op_count2;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    alu_f = a & b;
      3'd1:    alu_f = a | b;
      3'd2:    alu_f = a + b;
      3'd6:    alu_f = a - b;
      3'd7:    alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: alu_f = 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_z   = alu_f(alu_a, alu_b, alu_op);
  assign alu_ex  = (alu_z == 32'd0);
  assign alu_z2  = alu_f(alu_a2, alu_b2, alu_op2);
  assign alu_ex2 = (alu_z2 == 32'd0);

  alu_exec_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_z    (alu_z),
    .alu_ex   (alu_ex),
    .op_count (op_count)
  );

  alu_exec_stage #(.WIDTH(32), .CNT_W(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus2),
    .alu_a    (alu_a2),
    .alu_b    (alu_b2),
    .alu_op   (alu_op2),
    .alu_z    (alu_z2),
    .alu_ex   (alu_ex2),
    .op_count (op_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full transaction on dut from IDLE: accept, wait two edges, sample HOLD, hand off.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       output logic vld, output logic [31:0] z, output logic zf,
                       output logic ill);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    vld = bus.out_valid;
    z   = bus.out_z;
    zf  = bus.out_zero;
    ill = bus.out_illegal;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_op = '0; bus2.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0) begin n_fail++; $display("FAIL reset_alu_regs: got %h %h %0d want 0 0 0", alu_a, alu_b, alu_op); end
    n_tests++; if (bus.out_z !== 32'd0 || bus.out_zero !== 1'b0 || bus.out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_out_fields: got %h %b %b want 0 0 0", bus.out_z, bus.out_zero, bus.out_illegal); end
    n_tests++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
    rst_n = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_add();
    bus.in_valid = 1'b1; bus.in_a = 32'd5; bus.in_b = 32'd7; bus.in_op = 3'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_tests++; if (alu_op !== 3'd2 || alu_a !== 32'd5 || alu_b !== 32'd7) begin n_fail++; $display("FAIL add_accept_regs: got op=%0d a=%0d b=%0d want 2 5 7", alu_op, alu_a, alu_b); end
    n_tests++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL add_exec_flags: got rdy=%b vld=%b want 0 0", bus.in_ready, bus.out_valid); end
    @(posedge clk); #1;
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid_latency: got %b want 1", bus.out_valid); end
    n_tests++; if (bus.out_z !== 32'd12 || bus.out_zero !== 1'b0) begin n_fail++; $display("FAIL add_result: got %h %b want 0000000c 0", bus.out_z, bus.out_zero); end
    n_tests++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL add_count_before: got %0d want 0", op_count); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_tests++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL add_count_after: got %0d want 1", op_count); end
    n_tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL add_handoff_flags: got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_slt_sub();
    logic vld, zf, ill;
    logic [31:0] z;
    do_op(32'hFFFF_FFFF, 32'd1, 3'd7, vld, z, zf, ill);
    n_tests++; if (vld !== 1'b1 || z !== 32'd1 || zf !== 1'b0) begin n_fail++; $display("FAIL slt_neg: got vld=%b z=%h zf=%b want 1 00000001 0", vld, z, zf); end
    do_op(32'd7, 32'd7, 3'd6, vld, z, zf, ill);
    n_tests++; if (vld !== 1'b1 || z !== 32'd0 || zf !== 1'b1) begin n_fail++; $display("FAIL sub_zero: got vld=%b z=%h zf=%b want 1 00000000 1", vld, z, zf); end
    n_tests++; if (op_count !== 16'd3) begin n_fail++; $display("FAIL slt_sub_count: got %0d want 3", op_count); end
  endtask

  task automatic test_hold();
    bus.in_valid = 1'b1; bus.in_a = 32'hF0F0_F0F0; bus.in_b = 32'hFF00_FF00; bus.in_op = 3'd0;
    @(posedge clk); #1;
    // A second request stays pending across EXEC, HOLD and the handoff edge.
    bus.in_a = 32'd3; bus.in_b = 32'd4; bus.in_op = 3'd2;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (bus.out_valid !== 1'b1 || bus.out_z !== 32'hF000_F000 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_stable[%0d]: got vld=%b z=%h rdy=%b want 1 f000f000 0", i, bus.out_valid, bus.out_z, bus.in_ready); end
      n_tests++; if (alu_a !== 32'hF0F0_F0F0) begin n_fail++; $display("FAIL hold_alu_a[%0d]: got %h want f0f0f0f0", i, alu_a); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_tests++; if (op_count !== 16'd4) begin n_fail++; $display("FAIL hold_single_count: got %0d want 4", op_count); end
    n_tests++; if (alu_a !== 32'hF0F0_F0F0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL handoff_no_accept: got a=%h rdy=%b want f0f0f0f0 1", alu_a, bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_tests++; if (alu_a !== 32'd3 || alu_op !== 3'd2) begin n_fail++; $display("FAIL pending_accept: got a=%h op=%0d want 3 2", alu_a, alu_op); end
    @(posedge clk); #1;
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_z !== 32'd7) begin n_fail++; $display("FAIL pending_result: got vld=%b z=%h want 1 7", bus.out_valid, bus.out_z); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_tests++; if (op_count !== 16'd5) begin n_fail++; $display("FAIL pending_count: got %0d want 5", op_count); end
  endtask

  task automatic test_reset_exec();
    logic vld, zf, ill;
    logic [31:0] z;
    bus.in_valid = 1'b1; bus.in_a = 32'd9; bus.in_b = 32'd1; bus.in_op = 3'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_tests++; if (alu_a !== 32'd9) begin n_fail++; $display("FAIL rst_exec_pre: got a=%h want 9", alu_a); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_z !== 32'd0 || bus.out_zero !== 1'b0) begin n_fail++; $display("FAIL rst_exec_clear: got a=%h b=%h op=%0d vld=%b z=%h zf=%b want all 0", alu_a, alu_b, alu_op, bus.out_valid, bus.out_z, bus.out_zero); end
    n_tests++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL rst_exec_count: got %0d want 0", op_count); end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (op_count !== 16'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_exec_abandon: got cnt=%0d vld=%b rdy=%b want 0 0 1", op_count, bus.out_valid, bus.in_ready); end
    do_op(32'd2, 32'd3, 3'd2, vld, z, zf, ill);
    n_tests++; if (vld !== 1'b1 || z !== 32'd5 || op_count !== 16'd1) begin n_fail++; $display("FAIL rst_exec_next: got vld=%b z=%h cnt=%0d want 1 5 1", vld, z, op_count); end
  endtask

  task automatic test_illegal();
    logic vld, zf, ill;
    logic [31:0] z;
    do_op(32'd1, 32'd1, 3'd3, vld, z, zf, ill);
`ifdef ALU_EXEC_ILLEGAL_CHK_EN
    n_tests++; if (vld !== 1'b1 || ill !== 1'b1 || z !== 32'd0 || zf !== 1'b0) begin n_fail++; $display("FAIL illegal_op3: got vld=%b ill=%b z=%h zf=%b want 1 1 0 0", vld, ill, z, zf); end
`else
    n_tests++; if (vld !== 1'b1 || ill !== 1'b0 || z !== 32'hDEAD_BEEF || zf !== 1'b0) begin n_fail++; $display("FAIL illegal_op3: got vld=%b ill=%b z=%h zf=%b want 1 0 deadbeef 0", vld, ill, z, zf); end
`endif
    n_tests++; if (op_count !== 16'd2) begin n_fail++; $display("FAIL illegal_count: got %0d want 2", op_count); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_cnt [4];
    int waited;
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3;
    n_tests++; if (op_count2 !== 2'd0) begin n_fail++; $display("FAIL b2b_start_count: got %0d want 0", op_count2); end
    bus2.in_valid = 1'b1; bus2.in_a = 32'd10; bus2.in_b = 32'd1; bus2.in_op = 3'd2;
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      while (bus2.out_valid !== 1'b1 && waited < 10) begin
        @(posedge clk); #1;
        waited++;
      end
      n_tests++; if (bus2.out_valid !== 1'b1 || bus2.out_z !== 32'd11) begin n_fail++; $display("FAIL b2b_valid[%0d]: got vld=%b z=%h want 1 0000000b", i, bus2.out_valid, bus2.out_z); end
      @(posedge clk); #1;
      n_tests++; if (op_count2 !== exp_cnt[i]) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, op_count2, exp_cnt[i]); end
    end
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_add();
    test_slt_sub();
    test_hold();
    test_reset_exec();
    test_illegal();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
